// File: rtl/lt24_image_blitter.sv
// Raster-order full-frame pixel generator: a scaled image window fetched from a synchronous ROM,
// background colour elsewhere. One pixel per FETCH/WAIT/PRESENT pass, held in PRESENT until accepted.
module lt24_image_blitter #(
  parameter int          LCD_WIDTH   = 240,
  parameter int          LCD_HEIGHT  = 320,
  parameter int          PIC_X_START = 60,
  parameter int          PIC_Y_START = 0,
  parameter int          PIC_WIDTH   = 60,
  parameter int          PIC_HEIGHT  = 320,
  parameter int          X_SHIFT     = 1,
  parameter int          Y_SHIFT     = 0,
  parameter int          NUM_IMAGES  = 4,
  parameter int          ROM_AW      = 17,
  parameter int          ROM_LATENCY = 2,
  parameter logic [15:0] BACK_COLOR  = 16'h0000
) (
  input  logic              clock,
  input  logic              globalReset,
  input  logic              resetApp,
  input  logic              run,
  input  logic [1:0]        imageSel,
  input  logic              pixelReady,
  output logic              pixelWrite,
  output logic [7:0]        xAddr,
  output logic [8:0]        yAddr,
  output logic [15:0]       pixelData,
  output logic [ROM_AW-1:0] romAddr,
  input  logic [15:0]       romData,
  output logic              frameDone,
  output logic              busy
);

  localparam int CW = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
  localparam logic [CW-1:0]     WAIT_LAST = CW'(ROM_LATENCY - 1);
  localparam logic [7:0]        X_LAST    = 8'(LCD_WIDTH - 1);
  localparam logic [8:0]        Y_LAST    = 9'(LCD_HEIGHT - 1);
  localparam logic [ROM_AW-1:0] IMG_WORDS = ROM_AW'(PIC_WIDTH * PIC_HEIGHT);
  localparam logic [ROM_AW-1:0] PIC_W_A   = ROM_AW'(PIC_WIDTH);

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_WAIT, ST_PRESENT} state_t;

  state_t            state_q;
  logic [7:0]        x_q;
  logic [8:0]        y_q;
  logic [1:0]        sel_q;
  logic [ROM_AW-1:0] rom_addr_q;
  logic [15:0]       pix_q;
  logic              write_q, done_q, busy_q, in_win_q;
  logic [CW-1:0]     wait_q;

  logic [31:0]       x_off, y_off;
  logic              in_win;
  logic [ROM_AW-1:0] addr_d;
  logic [1:0]        sel_d;

  // Offsets wrap to huge values left of / above the window, so one unsigned compare covers both edges.
  always_comb begin
    x_off  = 32'(x_q) - 32'(PIC_X_START);
    y_off  = 32'(y_q) - 32'(PIC_Y_START);
    in_win = (x_off < 32'(PIC_WIDTH << X_SHIFT)) && (y_off < 32'(PIC_HEIGHT << Y_SHIFT));
    addr_d = ROM_AW'(sel_q) * IMG_WORDS + ROM_AW'(y_off >> Y_SHIFT) * PIC_W_A
           + ROM_AW'(x_off >> X_SHIFT);
    sel_d  = (32'(imageSel) < 32'(NUM_IMAGES)) ? imageSel : 2'd0;
  end

  always_ff @(posedge clock or posedge globalReset) begin
    if (globalReset) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      sel_q      <= '0;
      rom_addr_q <= '0;
      pix_q      <= BACK_COLOR;
      write_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      in_win_q   <= 1'b0;
      wait_q     <= '0;
    end else if (resetApp) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      sel_q      <= '0;
      rom_addr_q <= '0;
      pix_q      <= BACK_COLOR;
      write_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      in_win_q   <= 1'b0;
      wait_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (run) begin
            sel_q   <= sel_d;
            busy_q  <= 1'b1;
            state_q <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          rom_addr_q <= in_win ? addr_d : '0;
          in_win_q   <= in_win;
          wait_q     <= '0;
          state_q    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_q == WAIT_LAST) begin
            pix_q   <= in_win_q ? romData : BACK_COLOR;
            write_q <= 1'b1;
            state_q <= ST_PRESENT;
          end else begin
            wait_q <= wait_q + CW'(1);
          end
        end
        ST_PRESENT: begin
          if (pixelReady) begin
            write_q <= 1'b0;
            state_q <= ST_FETCH;
            if (x_q == X_LAST) begin
              x_q <= '0;
              if (y_q == Y_LAST) begin
                y_q    <= '0;
                done_q <= 1'b1;
                if (run) begin
                  sel_q <= sel_d;
                end else begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
                end
              end else begin
                y_q <= y_q + 9'd1;
              end
            end else begin
              x_q <= x_q + 8'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pixelWrite = write_q;
  assign xAddr      = x_q;
  assign yAddr      = y_q;
  assign pixelData  = pix_q;
  assign romAddr    = rom_addr_q;
  assign frameDone  = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_lt24_image_blitter.sv
// Randomised bench for lt24_image_blitter on a reduced frame, checked every cycle against a
// pixel-level reference model (expected pixel stream, cadence, frame boundaries).
module tb_lt24_image_blitter;

  localparam int LW = 24, LH = 10, PX = 6, PY = 2, PW = 5, PH = 3;
  localparam int XS = 1, YS = 1, NI = 3, AW = 8, LAT = 3;
  localparam logic [15:0] BACK = 16'hF81F;

  logic          clock, globalReset, resetApp, run, pixelReady;
  logic [1:0]    imageSel;
  logic          pixelWrite, frameDone, busy;
  logic [7:0]    xAddr;
  logic [8:0]    yAddr;
  logic [15:0]   pixelData, romData;
  logic [AW-1:0] romAddr, rom_pipe0, rom_pipe1;

  lt24_image_blitter #(
    .LCD_WIDTH(LW), .LCD_HEIGHT(LH), .PIC_X_START(PX), .PIC_Y_START(PY),
    .PIC_WIDTH(PW), .PIC_HEIGHT(PH), .X_SHIFT(XS), .Y_SHIFT(YS),
    .NUM_IMAGES(NI), .ROM_AW(AW), .ROM_LATENCY(LAT), .BACK_COLOR(BACK)
  ) dut (
    .clock(clock), .globalReset(globalReset), .resetApp(resetApp), .run(run),
    .imageSel(imageSel), .pixelReady(pixelReady), .pixelWrite(pixelWrite),
    .xAddr(xAddr), .yAddr(yAddr), .pixelData(pixelData), .romAddr(romAddr),
    .romData(romData), .frameDone(frameDone), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] rom_word(input logic [AW-1:0] a);
    return {a ^ 8'hC3, a};
  endfunction

  // Synchronous ROM: romData reflects the address registered LAT-1 edges earlier.
  always @(posedge clock) begin
    rom_pipe0 <= romAddr;
    rom_pipe1 <= rom_pipe0;
  end
  assign romData = rom_word(rom_pipe1);

  int checks = 0, errors = 0;
  int m_active = 0, m_x = 0, m_y = 0, m_sel = 0, m_cnt = 0, m_done = 0;
  int frames = 0, done_seen = 0;
  bit reached;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ROM word index of a screen pixel, or -1 outside the window.
  function automatic int pix_addr(input int x, input int y, input int s);
    if (x >= PX && x < PX + PW * (2 ** XS) && y >= PY && y < PY + PH * (2 ** YS))
      return s * PW * PH + ((y - PY) / (2 ** YS)) * PW + (x - PX) / (2 ** XS);
    return -1;
  endfunction

  function automatic int clamp_sel(input logic [1:0] s);
    return (int'(s) < NI) ? int'(s) : 0;
  endfunction

  function automatic logic rnd(input int pct);
    return $urandom_range(99) < pct;
  endfunction

  task automatic check_reset_values();
    check("rst_pixelWrite", 32'(pixelWrite), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_frameDone", 32'(frameDone), 0);
    check("rst_xAddr", 32'(xAddr), 0);
    check("rst_yAddr", 32'(yAddr), 0);
    check("rst_pixelData", 32'(pixelData), 32'(BACK));
    check("rst_romAddr", 32'(romAddr), 0);
  endtask

  task automatic model_reset();
    m_active = 0; m_x = 0; m_y = 0; m_cnt = 0; m_done = 0; m_sel = 0;
  endtask

  task automatic observe();
    int  a;
    logic exp_w;
    exp_w = (m_active != 0) && (m_cnt >= LAT + 1);
    a = pix_addr(m_x, m_y, m_sel);
    check("pixelWrite", 32'(pixelWrite), 32'(exp_w));
    check("busy", 32'(busy), 32'(m_active != 0));
    check("frameDone", 32'(frameDone), 32'(m_done));
    check("xAddr", 32'(xAddr), m_x);
    check("yAddr", 32'(yAddr), m_y);
    if (m_active != 0 && m_cnt >= 1)
      check("romAddr", 32'(romAddr), (a < 0) ? 0 : a);
    if (exp_w)
      check("pixelData", 32'(pixelData), (a < 0) ? 32'(BACK) : 32'(rom_word(AW'(a))));
    if (frameDone) done_seen++;
  endtask

  // Predict the effect of the coming rising edge given the inputs just driven.
  task automatic advance();
    if (resetApp) begin
      model_reset();
      return;
    end
    m_done = 0;
    if (m_active == 0) begin
      if (run) begin
        m_active = 1; m_sel = clamp_sel(imageSel); m_cnt = 0;
      end
    end else if (m_cnt >= LAT + 1 && pixelReady) begin
      m_cnt = 0;
      if (m_x == LW - 1 && m_y == LH - 1) begin
        m_x = 0; m_y = 0; m_done = 1; frames++;
        if (run) m_sel = clamp_sel(imageSel);
        else m_active = 0;
      end else if (m_x == LW - 1) begin
        m_x = 0; m_y++;
      end else begin
        m_x++;
      end
    end else begin
      m_cnt++;
    end
  endtask

  task automatic cycle(input logic rdy, input logic rn, input logic [1:0] sel, input logic rapp);
    @(negedge clock);
    observe();
    pixelReady = rdy;
    run        = rn;
    imageSel   = sel;
    resetApp   = rapp;
    advance();
  endtask

  initial begin
    globalReset = 1'b1; resetApp = 1'b0; run = 1'b0; imageSel = 2'd0; pixelReady = 1'b0;
    #2;
    check_reset_values();
    @(negedge clock);
    globalReset = 1'b0;

    // Idle with run low: ready toggling must be ignored.
    repeat (6) cycle(rnd(50), 1'b0, 2'($urandom_range(3)), 1'b0);

    // Random traffic across several frames; imageSel churns every cycle.
    repeat (5000) cycle(rnd(70), rnd(85), 2'($urandom_range(3)), 1'b0);

    // Abort a frame with resetApp at pixel (10,5).
    reached = 1'b0;
    for (int i = 0; i < 4000 && !reached; i++) begin
      cycle(rnd(70), 1'b1, 2'($urandom_range(3)), 1'b0);
      if (m_active != 0 && m_x == 10 && m_y == 5 && m_cnt >= LAT + 1) reached = 1'b1;
    end
    check("reach_pixel_10_5", 32'(reached), 1);
    cycle(1'b0, 1'b1, 2'd1, 1'b1);
    repeat (40) cycle(rnd(70), 1'b1, 2'($urandom_range(3)), 1'b0);

    // Long stall in PRESENT.
    reached = 1'b0;
    for (int i = 0; i < 50 && !reached; i++) begin
      cycle(1'b0, 1'b1, 2'($urandom_range(3)), 1'b0);
      if (m_active != 0 && m_cnt >= LAT + 1) reached = 1'b1;
    end
    check("reach_present", 32'(reached), 1);
    repeat (12) cycle(1'b0, 1'b1, 2'($urandom_range(3)), 1'b0);

    // Ready always high: minimum per-pixel cadence.
    repeat (1500) cycle(1'b1, 1'b1, 2'($urandom_range(3)), 1'b0);

    // Drop run and let the frame finish into IDLE.
    for (int i = 0; i < 4000 && m_active != 0; i++)
      cycle(rnd(80), 1'b0, 2'($urandom_range(3)), 1'b0);
    check("frame_ended", 32'(m_active), 0);
    repeat (8) cycle(rnd(50), 1'b0, 2'($urandom_range(3)), 1'b0);

    // Asynchronous reset while a pixel is presented.
    reached = 1'b0;
    for (int i = 0; i < 50 && !reached; i++) begin
      cycle(1'b0, 1'b1, 2'($urandom_range(3)), 1'b0);
      if (m_active != 0 && m_cnt >= LAT + 1) reached = 1'b1;
    end
    check("reach_present_rst", 32'(reached), 1);
    @(negedge clock);
    observe();
    globalReset = 1'b1;
    #1;
    check_reset_values();
    model_reset();
    run = 1'b0; pixelReady = 1'b1;
    @(negedge clock);
    globalReset = 1'b0;
    repeat (8) cycle(rnd(50), 1'b0, 2'($urandom_range(3)), 1'b0);

    check("frameDone_count", 32'(done_seen), 32'(frames));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
